// File: rtl/serial_adder_param.sv
// Bit-serial adder/subtractor.
// One full adder processes the operands LSB first, one bit per clock, so a
// WIDTH-bit result takes WIDTH RUN cycles followed by a one-cycle DONE pulse.
//
// Handshake: start is a request that is accepted on any rising edge where
// the block is in IDLE or DONE. In RUN it is ignored. There is no
// backpressure: the result on sum/carry is valid when done=1 and is held
// until the next completion.
module serial_adder_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             c_q,     c_d;
    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sr_next;

    // Full adder on the current low bits plus the running carry.
    always_comb begin
        fa_s    = a_q[0] ^ b_q[0] ^ c_q;
        fa_c    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        sr_next = {fa_s, sr_q[WIDTH-1:1]};
    end

    // Next-state logic: operand capture, per-bit shifting and result commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and seed carry with 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                c_d  = fa_c;
                sr_d = sr_next;
                if (cnt_q == LAST_BIT) begin
                    // Last bit: publish the assembled word; counter does not wrap.
                    sum_d   = sr_next;
                    carry_d = fa_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sr_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        sum       = sum_q;
        carry     = carry_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_serial_adder_param.sv
// Bench for serial_adder_param at WIDTH = 4, 8 and 16.
module tb_serial_adder_param;

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_carry;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start_drv;
    logic        sub_drv;
    logic        cin_drv;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    int          sel_w;

    logic        start4, start8, start16;
    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;
    logic [3:0]  sum4;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic        carry4, carry8, carry16;
    logic [1:0]  st4, st8, st16;

    logic        busy_s, done_s, carry_s;
    logic [15:0] sum_s;
    logic [1:0]  st_s;

    int checks;
    int failures;
    logic [15:0] prev_sum [17];
    logic [16:0] exp_q [$];

    assign start4  = start_drv && (sel_w == 4);
    assign start8  = start_drv && (sel_w == 8);
    assign start16 = start_drv && (sel_w == 16);

    serial_adder_param #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub_drv),
        .a(a_drv[3:0]), .b(b_drv[3:0]), .cin(cin_drv),
        .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .dbg_state(st4)
    );

    serial_adder_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub_drv),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .dbg_state(st8)
    );

    serial_adder_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub_drv),
        .a(a_drv), .b(b_drv), .cin(cin_drv),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .dbg_state(st16)
    );

    always_comb begin
        busy_s  = busy8;
        done_s  = done8;
        sum_s   = {8'b0, sum8};
        carry_s = carry8;
        st_s    = st8;
        case (sel_w)
            4: begin
                busy_s = busy4; done_s = done4; sum_s = {12'b0, sum4};
                carry_s = carry4; st_s = st4;
            end
            16: begin
                busy_s = busy16; done_s = done16; sum_s = sum16;
                carry_s = carry16; st_s = st16;
            end
            default: ;
        endcase
    end

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         output logic [15:0] s, output logic c);
        longint mask;
        longint av;
        longint bv;
        longint full;
        mask = (longint'(1) << w) - 1;
        av   = longint'(a) & mask;
        bv   = longint'(b) & mask;
        if (sub) begin
            s = 16'((av - bv) & mask);
            c = (av >= bv);
        end else begin
            full = av + bv + longint'(cin);
            s = 16'(full & mask);
            c = ((full >> w) & 1) != 0;
        end
    endtask

    task automatic randomize_inputs();
        a_drv   = 16'($urandom);
        b_drv   = 16'($urandom);
        cin_drv = 1'($urandom_range(0, 1));
        sub_drv = 1'($urandom_range(0, 1));
    endtask

    // Drives one operation on the selected width and checks timing and hold.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic c);
        int n;
        sel_w = w;
        @(negedge clk);
        a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub;
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        check($sformatf("w%0d_accept_busy", w), 64'(busy_s), 64'd1);
        check($sformatf("w%0d_accept_done", w), 64'(done_s), 64'd0);
        n = 0;
        while (!done_s && n < 100) begin
            check($sformatf("w%0d_sum_hold", w), 64'(sum_s), 64'(prev_sum[w]));
            randomize_inputs();
            start_drv = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        start_drv = 1'b0;
        check($sformatf("w%0d_latency", w), 64'(n), 64'(w));
        check($sformatf("w%0d_done_seen", w), 64'(done_s), 64'd1);
        s = sum_s;
        c = carry_s;
        prev_sum[w] = sum_s;
        @(posedge clk);
        #1;
        check($sformatf("w%0d_done_pulse", w), 64'(done_s), 64'd0);
        check($sformatf("w%0d_idle_busy", w), 64'(busy_s), 64'd0);
    endtask

    task automatic run_and_compare(input string tag, input int w,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [15:0] got_s, exp_s;
        logic        got_c, exp_c;
        model(w, a, b, cin, sub, exp_s, exp_c);
        run_op(w, a, b, cin, sub, got_s, got_c);
        check({tag, "_sum"}, 64'(got_s), 64'(exp_s));
        check({tag, "_carry"}, 64'(got_c), 64'(exp_c));
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs [9];
        logic [15:0] got_s;
        logic        got_c;
        logic [15:0] op_a [4];
        logic [15:0] op_b [4];
        logic        op_sub [4];
        logic [15:0] es;
        logic        ec;
        logic [16:0] popped;
        int          k;
        int          cyc;
        int          guard;
        bit          pending;

        vecs[0] = '{8,  16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0};
        vecs[1] = '{8,  16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1};
        vecs[2] = '{8,  16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0};
        vecs[3] = '{8,  16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1};
        vecs[4] = '{8,  16'h0003, 16'h0005, 1'b1, 1'b1, 16'h00FE, 1'b0};
        vecs[5] = '{4,  16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{4,  16'h0003, 16'h0005, 1'b0, 1'b1, 16'h000E, 1'b0};
        vecs[7] = '{16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[8] = '{16, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1};

        checks = 0;
        failures = 0;
        for (int i = 0; i < 17; i++) prev_sum[i] = '0;
        rst_n = 1'b0;
        start_drv = 1'b0;
        sel_w = 8;
        a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0;

        // Reset state of every instance.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'({busy4, busy8, busy16}), 64'd0);
        check("rst_done",  64'({done4, done8, done16}), 64'd0);
        check("rst_sum",   64'({sum4, sum8, sum16}), 64'd0);
        check("rst_carry", 64'({carry4, carry8, carry16}), 64'd0);
        check("rst_state", 64'({st4, st8, st16}), 64'd0);

        // Inputs wiggling with start=0 must not move any state.
        repeat (4) begin
            @(negedge clk);
            randomize_inputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            randomize_inputs();
        end
        check("idle_ignore_state", 64'({st4, st8, st16}), 64'd0);
        check("idle_ignore_sum",   64'({sum4, sum8, sum16}), 64'd0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, got_s, got_c);
            check($sformatf("vec%0d_sum", i), 64'(got_s), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_carry", i), 64'(got_c), 64'(vecs[i].exp_carry));
        end

        // Exhaustive WIDTH=4.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_and_compare("w4_add0", 4, 16'(ia), 16'(ib), 1'b0, 1'b0);
                run_and_compare("w4_add1", 4, 16'(ia), 16'(ib), 1'b1, 1'b0);
                run_and_compare("w4_sub",  4, 16'(ia), 16'(ib), 1'($urandom_range(0, 1)), 1'b1);
            end
        end

        // Random WIDTH=8 and WIDTH=16.
        for (int i = 0; i < 100; i++) begin
            run_and_compare("w8_rand", 8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 120; i++) begin
            run_and_compare("w16_rand", 16, 16'($urandom), 16'($urandom),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back on WIDTH=8 with start held high throughout.
        for (int i = 0; i < 4; i++) begin
            op_a[i]   = 16'($urandom_range(0, 255));
            op_b[i]   = 16'($urandom_range(0, 255));
            op_sub[i] = 1'($urandom_range(0, 1));
        end
        sel_w = 8;
        @(negedge clk);
        a_drv = op_a[0]; b_drv = op_b[0]; sub_drv = op_sub[0]; cin_drv = 1'b0;
        model(8, op_a[0], op_b[0], 1'b0, op_sub[0], es, ec);
        exp_q.push_back({ec, es});
        start_drv = 1'b1;
        k = 1;
        @(posedge clk);
        #1;
        cyc = 0;
        pending = 1'b0;
        check("b2b_accept_busy", 64'(busy_s), 64'd1);
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            if (done_s) begin
                check("b2b_period", 64'(cyc), 64'd8);
                popped = exp_q.pop_front();
                check("b2b_sum", 64'(sum_s), 64'(popped[15:0]));
                check("b2b_carry", 64'(carry_s), 64'(popped[16]));
                check("b2b_done_busy", 64'(busy_s), 64'd0);
                if (k < 4) begin
                    a_drv = op_a[k]; b_drv = op_b[k]; sub_drv = op_sub[k];
                    cin_drv = 1'($urandom_range(0, 1));
                    model(8, op_a[k], op_b[k], cin_drv, op_sub[k], es, ec);
                    exp_q.push_back({ec, es});
                    k++;
                    pending = 1'b1;
                end else begin
                    start_drv = 1'b0;
                end
                cyc = -1;
            end else begin
                a_drv = 16'($urandom);
                b_drv = 16'($urandom);
                sub_drv = 1'($urandom_range(0, 1));
                cin_drv = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            cyc++;
            guard++;
            if (pending) begin
                check("b2b_rearm_busy", 64'(busy_s), 64'd1);
                check("b2b_rearm_done", 64'(done_s), 64'd0);
                pending = 1'b0;
            end
        end
        start_drv = 1'b0;
        check("b2b_all_done", 64'(exp_q.size()), 64'd0);
        check("b2b_end_done", 64'(done_s), 64'd0);
        check("b2b_end_busy", 64'(busy_s), 64'd0);
        prev_sum[8] = sum_s;

        // Reset in the middle of a WIDTH=8 operation.
        run_and_compare("pre_rst", 8, 16'h000F, 16'h0001, 1'b0, 1'b0);
        sel_w = 8;
        @(negedge clk);
        a_drv = 16'h0055; b_drv = 16'h0022; cin_drv = 1'b0; sub_drv = 1'b0;
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_busy_before", 64'(busy_s), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy",  64'(busy_s), 64'd0);
        check("midrun_rst_done",  64'(done_s), 64'd0);
        check("midrun_rst_sum",   64'(sum_s), 64'd0);
        check("midrun_rst_carry", 64'(carry_s), 64'd0);
        check("midrun_rst_state", 64'(st_s), 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("midrun_no_done", 64'(done_s), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) prev_sum[i] = '0;
        run_and_compare("post_rst", 8, 16'h0055, 16'h0022, 1'b0, 1'b0);
        check("post_rst_const", 64'(prev_sum[8]), 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/serial_adder_param.md
SERIAL_ADDER_PARAM -- requirements
Module: serial_adder_param

Interface
REQ-001: Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002: Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003: Port rst_n  input  1  asynchronous, active-low reset.
REQ-004: Port start  input  1  request to begin an operation; sampled on rising clk.
REQ-005: Port sub  input  1  mode select, sampled with start: 0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored).
REQ-006: Port a  input  WIDTH  first operand, captured when start is accepted.
REQ-007: Port b  input  WIDTH  second operand, captured when start is accepted.
REQ-008: Port cin  input  1  carry-in for add mode, captured when start is accepted.
REQ-009: Port busy  output  1  high while the operation is in progress (RUN state).
REQ-010: Port done  output  1  single-cycle pulse marking valid new sum and carry.
REQ-011: Port sum  output  WIDTH  registered result, LSB-first assembled.
REQ-012: Port carry  output  1  registered carry-out (add) or no-borrow flag (sub, 1 = a>=b unsigned).

Function
REQ-013: The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014: In IDLE or DONE, start=1 at an edge SHALL be accepted: capture a, b (inverted if sub=1), initial carry (cin if sub=0, 1 if sub=1); clear the bit counter; go to RUN.
REQ-015: start SHALL be ignored while in RUN; captured operands and mode SHALL NOT change mid-operation.
REQ-016: Each RUN cycle SHALL add one bit pair (LSB first) plus the carry flop via a full adder, shift the sum bit into the sum shift register MSB, update the carry flop, and increment the bit counter.
REQ-017: The bit counter SHALL be $clog2(WIDTH) bits wide; RUN SHALL end on the edge processing bit WIDTH-1, with no wrap into a further bit.
REQ-018: Latency: start accepted at edge N SHALL update sum and carry at edge N+WIDTH, with done=1 for exactly the cycle following edge N+WIDTH (state DONE).
REQ-019: busy SHALL be 1 from edge N through edge N+WIDTH (exactly WIDTH cycles) and 0 otherwise.
REQ-020: DONE SHALL last one cycle, returning to IDLE unless start=1 (back-to-back: next RUN begins, done falls, busy rises).
REQ-021: sum and carry SHALL hold their last result until the next completion; internal shift contents SHALL NOT be visible on sum during RUN.
REQ-022: Results SHALL be modulo 2^WIDTH; carry SHALL be the carry out of bit WIDTH-1.
REQ-023: X on a, b, cin or sub SHALL not affect state while start=0.

Reset
REQ-024: rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, sum=0, carry=0, counter=0, internal operand/carry flops=0.
REQ-025: Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start in IDLE.
REQ-026: Deassertion of rst_n SHALL be followed by correct operation starting with the first clk edge after release.

Verification
REQ-027: WIDTH=8, a=0x0F, b=0x01, cin=0, sub=0, start pulse at edge N -> busy 8 cycles, done one cycle after edge N+8, sum=0x10, carry=0.
REQ-028: WIDTH=8, a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, carry=1; 1-bit slice a=1,b=1,cin=0 matches half-adder truth (sum bit 0, carry into bit 1).
REQ-029: WIDTH=8, sub=1: a=0x05,b=0x03 -> sum=0x02, carry=1; a=0x03,b=0x05 -> sum=0xFE, carry=0.
REQ-030: start held high continuously with new operands at each DONE -> back-to-back results every WIDTH+1 cycles; start pulses during RUN ignored, operands unchanged.
REQ-031: rst_n pulled low at RUN bit 3 -> outputs zero immediately, no done; new start after release gives correct result.
REQ-032: Repeat REQ-027..029 for WIDTH=4 and WIDTH=16 with random operands against a + b + cin reference model; exhaustive for WIDTH=4.
